pixel_color_packer: RTL

- Sits directly downstream of get_pixel_color in the ray-trace pipeline.
- Accepts float32 r/g/b shading results with pixel coordinates, saturates each channel to 8 bits, and packs the result to RGB565.
- Buffers results in a small FIFO and issues framebuffer BRAM writes over a valid/ready handshake.
- Pulses frame_done_out when the last pixel of a frame is written.

---
 rtl/pixel_color_packer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pixel_color_packer.sv
// Converts float32 RGB shading results to RGB565, buffers them in a small FIFO and
// issues framebuffer writes over a valid/ready handshake with a frame-done pulse.
module pixel_color_packer #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 180,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [10:0]       x_in,
    input  logic [9:0]        y_in,
    input  logic [31:0]       r_in,
    input  logic [31:0]       g_in,
    input  logic [31:0]       b_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [15:0]       wr_data_out,
    output logic              wr_valid_out,
    input  logic              wr_ready_in,
    output logic              frame_done_out,
    output logic              range_err_out
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [10:0] X_MAX = 11'(H_RES - 1);
    localparam logic [9:0]  Y_MAX = 10'(V_RES - 1);

    // Saturating float32 -> 8-bit channel; the shift is only used for 119 <= e <= 126.
    function automatic logic [7:0] float_to_c8(input logic [31:0] f);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [23:0] shifted;
        logic [7:0]  c8;
        s       = f[31];
        e       = f[30:23];
        m       = f[22:0];
        shifted = {1'b1, m} >> 5'(8'd142 - e);
        if (s) begin
            c8 = 8'd0;
        end else if (e == 8'd255 && m != 23'd0) begin
            c8 = 8'd0;
        end else if (e >= 8'd127) begin
            c8 = 8'd255;
        end else if (e < 8'd119) begin
            c8 = 8'd0;
        end else begin
            c8 = shifted[7:0];
        end
        return c8;
    endfunction

    logic              s1_valid_r;
    logic [31:0]       s1_red_r, s1_grn_r, s1_blu_r;
    logic [10:0]       s1_x_r;
    logic [9:0]        s1_y_r;

    logic              s2_valid_r, s2_oor_r, s2_last_r;
    logic [15:0]       s2_pix_r;
    logic [ADDR_W-1:0] s2_addr_r;

    logic [15:0]       mem_data_r [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_addr_r [FIFO_DEPTH];
    logic              mem_last_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              ready_r, wr_valid_r, frame_done_r, range_err_r, out_last_r;
    logic [15:0]       out_data_r;
    logic [ADDR_W-1:0] out_addr_r;

    logic              accept_s, push_s, pop_s, head_load_s;
    logic [7:0]        r8_s, g8_s, b8_s;
    logic [15:0]       pix_s;
    logic [ADDR_W-1:0] addr_s;
    logic              oor_s, last_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [PTR_W-1:0]  rd_ptr_next_s;
    logic [CNT_W:0]    occupancy_next_s;
    logic              ready_next_s;
    logic [15:0]       head_data_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic              head_last_s;

    // Handshakes, stage-2 conversion, FIFO bookkeeping and next head selection.
    always_comb begin
        accept_s      = valid_in && ready_r;
        push_s        = s2_valid_r && !s2_oor_r;
        pop_s         = wr_valid_r && wr_ready_in;
        r8_s          = float_to_c8(s1_red_r);
        g8_s          = float_to_c8(s1_grn_r);
        b8_s          = float_to_c8(s1_blu_r);
        pix_s         = {r8_s[7:3], g8_s[7:2], b8_s[7:3]};
        addr_s        = ADDR_W'(s1_y_r) * ADDR_W'(H_RES) + ADDR_W'(s1_x_r);
        oor_s         = (s1_x_r > X_MAX) || (s1_y_r > Y_MAX);
        last_s        = (s1_x_r == X_MAX) && (s1_y_r == Y_MAX);
        cnt_next_s    = cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
        rd_ptr_next_s = rd_ptr_r;
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        // Pipeline stages still holding a sample count against the FIFO so a push never overflows it.
        occupancy_next_s = {1'b0, cnt_next_s} + (CNT_W+1)'(accept_s) + (CNT_W+1)'(s1_valid_r);
        ready_next_s     = occupancy_next_s <= (CNT_W+1)'(FIFO_DEPTH - 1);
        head_load_s      = cnt_next_s != {CNT_W{1'b0}};
        // A push into the slot the head is about to point at bypasses the memory.
        if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_data_s = s2_pix_r;
            head_addr_s = s2_addr_r;
            head_last_s = s2_last_r;
        end else begin
            head_data_s = mem_data_r[rd_ptr_next_s];
            head_addr_s = mem_addr_r[rd_ptr_next_s];
            head_last_s = mem_last_r[rd_ptr_next_s];
        end
    end

    // FIFO storage; contents are qualified by the count, so no reset is needed.
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            mem_data_r[wr_ptr_r] <= s2_pix_r;
            mem_addr_r[wr_ptr_r] <= s2_addr_r;
            mem_last_r[wr_ptr_r] <= s2_last_r;
        end
    end

    // Pipeline, FIFO pointers and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            s1_valid_r   <= 1'b0;
            s1_red_r     <= 32'd0;
            s1_grn_r     <= 32'd0;
            s1_blu_r     <= 32'd0;
            s1_x_r       <= 11'd0;
            s1_y_r       <= 10'd0;
            s2_valid_r   <= 1'b0;
            s2_oor_r     <= 1'b0;
            s2_last_r    <= 1'b0;
            s2_pix_r     <= 16'd0;
            s2_addr_r    <= {ADDR_W{1'b0}};
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            ready_r      <= 1'b0;
            wr_valid_r   <= 1'b0;
            out_data_r   <= 16'd0;
            out_addr_r   <= {ADDR_W{1'b0}};
            out_last_r   <= 1'b0;
            frame_done_r <= 1'b0;
            range_err_r  <= 1'b0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_red_r <= r_in;
                s1_grn_r <= g_in;
                s1_blu_r <= b_in;
                s1_x_r   <= x_in;
                s1_y_r   <= y_in;
            end
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_pix_r  <= pix_s;
                s2_addr_r <= addr_s;
                s2_oor_r  <= oor_s;
                s2_last_r <= last_s;
            end
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r   <= rd_ptr_next_s;
            cnt_r      <= cnt_next_s;
            ready_r    <= ready_next_s;
            wr_valid_r <= head_load_s;
            if (head_load_s) begin
                out_data_r <= head_data_s;
                out_addr_r <= head_addr_s;
                out_last_r <= head_last_s;
            end
            frame_done_r <= pop_s && out_last_r;
            range_err_r  <= range_err_r || (s2_valid_r && s2_oor_r);
        end
    end

    assign ready_out      = ready_r;
    assign wr_valid_out   = wr_valid_r;
    assign wr_data_out    = out_data_r;
    assign wr_addr_out    = out_addr_r;
    assign frame_done_out = frame_done_r;
    assign range_err_out  = range_err_r;

endmodule
